output_vc_arbiter: RTL and testbench
====================================

Name: output_vc_arbiter

Overview:
- Per-output-port arbiter for the ExaNet switch with virtual channels.
- Each input presents one request bit per (priority, VC) pair.
- The block picks one (input, VC) winner per packet, checking downstream credit availability, and asserts clear-to-send (cts) until the packet's last beat.
- It sits between the input VC buffers and the output crossbar mux, and drives the mux select.

Parameters:
- vc_num, 3, virtual channels per priority level
- prio_num, 2, priority levels; level prio_num-1 is the highest
- input_num, 4, switch inputs competing for this output

Ports:
- clk  input  1  clock
- rst  input  1  asynchronous, active-high reset
- i_request  input  [vc_num*prio_num-1:0] x input_num (unpacked array)  per-input requests; bit k = p*vc_num + v
- i_credit_avail  input  vc_num*prio_num  per-(p,v) downstream credit available (level)
- i_valid  input  1  beat valid from the selected input
- i_last  input  1  last beat of the packet; meaningful only with i_valid
- o_cts  output  1  clear-to-send to the selected input; high for the whole grant
- o_selected_input  output  $clog2(input_num)  crossbar select
- o_selected_vc  output  $clog2(vc_num*prio_num)  granted request bit index k
- o_pkt_done  output  1  one-cycle pulse when the last beat is accepted
- o_abort  output  1  one-cycle pulse when a granted request is withdrawn before its first beat

Behaviour:
- Reset (asynchronous, rst=1): state=IDLE; o_cts=0, o_selected_input=0, o_selected_vc=0, o_pkt_done=0, o_abort=0; all round-robin pointers=0.
- Candidate (i,k) is eligible when i_request[i][k] & i_credit_avail[k].
- Arbitration, combinational in IDLE:
  - Choose the highest p that has any eligible candidate.
  - Within that level, scan the flat index j = i*vc_num + v (0..input_num*vc_num-1).
  - The scan is round-robin, starting at rr_ptr[p] and wrapping past the top index.
  - Only rr_ptr[p] of the winning level updates, to (winner j + 1) mod (input_num*vc_num). It updates on the grant cycle.
- FSM:
  - IDLE: if any candidate is eligible, register the winner and go to GRANT. o_cts rises the next cycle, giving 1-cycle request-to-cts latency. Otherwise stay in IDLE.
  - GRANT: o_cts=1 and the select outputs are held stable.
    - A beat is accepted when i_valid & o_cts.
    - started flag: set on the first accepted beat, cleared on entry to GRANT.
  - GRANT -> IDLE on i_valid & i_last: pulse o_pkt_done in that same cycle.
  - GRANT -> IDLE when !started and the winner's request bit is 0: pulse o_abort, go to IDLE, and do not roll back rr_ptr.
  - Once started, a request drop is ignored; the grant holds until last.
- Credits are sampled only at arbitration. Losing credit mid-packet does not stop the packet; flow control of the packet is the input's job.
- i_last arriving on the same cycle as the first beat (single-beat packet) is legal: o_pkt_done pulses and started is irrelevant.
- There is no bypass. After o_pkt_done or o_abort at cycle M, state is IDLE at M+1 and the next o_cts is at M+2 at the earliest. This one-cycle bubble is mandatory.
- i_valid/i_last seen while in IDLE are ignored.
- Requests changing in the cycle of o_pkt_done have no effect until IDLE.
- All outputs are registered. The select outputs keep their last values in IDLE; o_cts=0 in IDLE.

Decomposition:
- Shared package (exanet_vc_pkg): typedefs for the request vector and VC index, the state enum {IDLE, GRANT}, and a function mapping (p,v) to k.
- One sub-module, rr_find_first, is natural. It is a parameterized round-robin first-one finder: width N, pointer in; found flag and index out.
- Instantiate rr_find_first once per priority level inside a generate loop. The FSM stays in the top level.

Test Plan (input_num=4, vc_num=3, prio_num=2):
1. Reset, then single request: i_request[2][4]=1, all credits=1 -> o_cts=1 one cycle later, o_selected_input=2, o_selected_vc=4. Three beats with i_last on the third -> o_pkt_done pulses with the last beat; o_cts=0 on the next cycle.
2. Priority: i_request[0][1]=1 (p0) and i_request[3][3]=1 (p1) simultaneously -> input 3, vc 3 wins. After its packet the bubble cycle occurs, then input 0, vc 1 is granted.
3. Round-robin: all four inputs request k=0 continuously with one-beat packets -> grant order 0,1,2,3,0, with o_cts low for exactly one cycle between grants.
4. Credit masking: i_credit_avail[5]=0, i_request[1][5]=1, i_request[2][2]=1 -> input 2 wins. Set credit[5]=1 -> input 1 is granted after input 2's packet.
5. Abort: grant input 1 at k=2, then drop i_request[1][2] before any i_valid -> o_abort pulse, IDLE. Dropping the request after the first beat must NOT abort; the grant holds until i_last.
6. Reset mid-packet: assert rst while in GRANT -> o_cts=0 immediately (asynchronous). After release, rr_ptr=0 and input 0 wins a full tie again.

Source files
------------

// File: rtl/exanet_vc_pkg.sv
// rtl/exanet_vc_pkg.sv - shared types and helpers for the ExaNet output VC arbiter
package exanet_vc_pkg;

  localparam int VC_NUM    = 3;
  localparam int PRIO_NUM  = 2;
  localparam int INPUT_NUM = 4;
  localparam int REQ_W     = VC_NUM * PRIO_NUM;
  localparam int VC_IDX_W  = $clog2(REQ_W);

  typedef logic [REQ_W-1:0]    req_vec_t;
  typedef logic [VC_IDX_W-1:0] vc_idx_t;

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } arb_state_e;

  // Request bit k for virtual channel v at priority level p
  function automatic int vc_flat_index(input int p, input int v, input int vc_per_prio);
    return p * vc_per_prio + v;
  endfunction

endpackage

// File: rtl/rr_find_first.sv
// rtl/rr_find_first.sv - round-robin first-one finder starting at a pointer
module rr_find_first #(
  parameter  int N = 12,
  localparam int W = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0] req,
  input  logic [W-1:0] ptr,
  output logic         found,
  output logic [W-1:0] idx
);

  // Walk the request vector from ptr upward, wrapping past the top bit
  always_comb begin
    int pos;
    found = 1'b0;
    idx   = '0;
    pos   = 0;
    for (int off = 0; off < N; off++) begin
      pos = int'(ptr) + off;
      if (pos >= N) pos = pos - N;
      if (!found && req[pos]) begin
        found = 1'b1;
        idx   = W'(pos);
      end
    end
  end

endmodule

// File: rtl/output_vc_arbiter.sv
// rtl/output_vc_arbiter.sv - per-output (input, VC) arbiter with credit check and clear-to-send
module output_vc_arbiter
  import exanet_vc_pkg::*;
#(
  parameter  int vc_num    = VC_NUM,
  parameter  int prio_num  = PRIO_NUM,
  parameter  int input_num = INPUT_NUM,
  localparam int req_w     = vc_num * prio_num,
  localparam int in_w      = (input_num > 1) ? $clog2(input_num) : 1,
  localparam int k_w       = (req_w > 1) ? $clog2(req_w) : 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [req_w-1:0] i_request [input_num],
  input  logic [req_w-1:0] i_credit_avail,
  input  logic             i_valid,
  input  logic             i_last,
  output logic             o_cts,
  output logic [in_w-1:0]  o_selected_input,
  output logic [k_w-1:0]   o_selected_vc,
  output logic             o_pkt_done,
  output logic             o_abort
);

  localparam int flat_n = input_num * vc_num;
  localparam int flat_w = (flat_n > 1) ? $clog2(flat_n) : 1;
  localparam int prio_w = (prio_num > 1) ? $clog2(prio_num) : 1;

  arb_state_e        state;
  logic              started;
  logic [flat_w-1:0] rr_ptr    [prio_num];
  logic [flat_n-1:0] lvl_req   [prio_num];
  logic [flat_w-1:0] lvl_idx   [prio_num];
  logic [prio_num-1:0] lvl_found;

  logic              any_found;
  logic [prio_w-1:0] win_p;
  logic [flat_w-1:0] win_j;
  logic [flat_w-1:0] win_next_ptr;
  logic [in_w-1:0]   win_in;
  logic [k_w-1:0]    win_k;
  logic              granted_req;

  // Per level, lay out eligible (request and credit) candidates as j = input*vc_num + vc
  always_comb begin
    for (int p = 0; p < prio_num; p++) begin
      lvl_req[p] = '0;
      for (int i = 0; i < input_num; i++) begin
        for (int v = 0; v < vc_num; v++) begin
          lvl_req[p][i*vc_num+v] = i_request[i][vc_flat_index(p, v, vc_num)]
                                 & i_credit_avail[vc_flat_index(p, v, vc_num)];
        end
      end
    end
  end

  for (genvar gp = 0; gp < prio_num; gp++) begin : g_level
    rr_find_first #(.N(flat_n)) u_find (
      .req   (lvl_req[gp]),
      .ptr   (rr_ptr[gp]),
      .found (lvl_found[gp]),
      .idx   (lvl_idx[gp])
    );
  end

  // Highest level with a candidate wins; decode its flat index back to (input, k)
  always_comb begin
    any_found = 1'b0;
    win_p     = '0;
    win_j     = '0;
    win_in    = '0;
    win_k     = '0;
    for (int p = 0; p < prio_num; p++) begin
      if (lvl_found[p]) begin
        any_found = 1'b1;
        win_p     = prio_w'(p);
        win_j     = lvl_idx[p];
      end
    end
    for (int i = 0; i < input_num; i++) begin
      for (int v = 0; v < vc_num; v++) begin
        if (int'(win_j) == i*vc_num + v) begin
          win_in = in_w'(i);
          win_k  = k_w'(vc_flat_index(int'(win_p), v, vc_num));
        end
      end
    end
    win_next_ptr = (int'(win_j) == flat_n - 1) ? '0 : win_j + 1'b1;
  end

  // Request bit of the current grant holder, watched for withdrawal before the first beat
  always_comb begin
    granted_req = i_request[o_selected_input][o_selected_vc];
  end

  // Grant FSM: arbitrate in IDLE, hold the grant until the last beat or an early withdrawal
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state            <= IDLE;
      started          <= 1'b0;
      o_cts            <= 1'b0;
      o_selected_input <= '0;
      o_selected_vc    <= '0;
      o_pkt_done       <= 1'b0;
      o_abort          <= 1'b0;
      for (int p = 0; p < prio_num; p++) rr_ptr[p] <= '0;
    end else begin
      o_pkt_done <= 1'b0;
      o_abort    <= 1'b0;
      case (state)
        IDLE: begin
          if (any_found) begin
            state            <= GRANT;
            started          <= 1'b0;
            o_cts            <= 1'b1;
            o_selected_input <= win_in;
            o_selected_vc    <= win_k;
            rr_ptr[win_p]    <= win_next_ptr;
          end
        end
        GRANT: begin
          if (i_valid && i_last) begin
            state      <= IDLE;
            o_cts      <= 1'b0;
            o_pkt_done <= 1'b1;
          end else if (i_valid) begin
            started <= 1'b1;
          end else if (!started && !granted_req) begin
            state   <= IDLE;
            o_cts   <= 1'b0;
            o_abort <= 1'b1;
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_output_vc_arbiter.sv
// tb/tb_output_vc_arbiter.sv - self-checking bench for output_vc_arbiter
module tb_output_vc_arbiter;

  logic       clk = 1'b0;
  logic       rst;
  logic [5:0] req [4];
  logic [5:0] credit;
  logic       valid;
  logic       last;
  logic       cts;
  logic [1:0] sel_in;
  logic [2:0] sel_vc;
  logic       pkt_done;
  logic       abort;

  int n_checks = 0;
  int n_pass   = 0;

  // reference model state
  bit m_busy, m_started, m_done, m_abort;
  int m_in, m_k;
  int m_ptr [2];

  always #5 clk = ~clk;

  output_vc_arbiter dut (
    .clk              (clk),
    .rst              (rst),
    .i_request        (req),
    .i_credit_avail   (credit),
    .i_valid          (valid),
    .i_last           (last),
    .o_cts            (cts),
    .o_selected_input (sel_in),
    .o_selected_vc    (sel_vc),
    .o_pkt_done       (pkt_done),
    .o_abort          (abort)
  );

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
  endtask

  task automatic model_reset();
    m_busy = 0; m_started = 0; m_done = 0; m_abort = 0;
    m_in = 0; m_k = 0; m_ptr[0] = 0; m_ptr[1] = 0;
  endtask

  // One clock of the specified behaviour, from the inputs present at the edge
  task automatic model_step();
    bit found;
    int j, i, v, k;
    m_done = 0;
    m_abort = 0;
    if (!m_busy) begin
      found = 0;
      for (int p = 1; p >= 0; p--) begin
        for (int off = 0; off < 12; off++) begin
          j = (m_ptr[p] + off) % 12;
          i = j / 3;
          v = j % 3;
          k = p * 3 + v;
          if (!found && req[i][k] && credit[k]) begin
            found = 1; m_in = i; m_k = k; m_ptr[p] = (j + 1) % 12;
          end
        end
      end
      if (found) begin m_busy = 1; m_started = 0; end
    end else begin
      if (valid && last) begin m_busy = 0; m_done = 1; end
      else if (valid) m_started = 1;
      else if (!m_started && !req[m_in][m_k]) begin m_busy = 0; m_abort = 1; end
    end
  endtask

  task automatic compare();
    check("cts", int'(cts), int'(m_busy));
    check("sel_in", int'(sel_in), m_in);
    check("sel_vc", int'(sel_vc), m_k);
    check("pkt_done", int'(pkt_done), int'(m_done));
    check("abort", int'(abort), int'(m_abort));
  endtask

  task automatic cycle();
    @(posedge clk);
    model_step();
    @(negedge clk);
    compare();
  endtask

  task automatic clear_inputs();
    for (int i = 0; i < 4; i++) req[i] = '0;
    credit = 6'h3F; valid = 0; last = 0;
  endtask

  task automatic do_reset();
    rst = 1;
    clear_inputs();
    model_reset();
    @(negedge clk);
    @(negedge clk);
    rst = 0;
    compare();
  endtask

  task automatic lit_grant(input string name, input int in, input int k);
    check({name, "_cts"}, int'(cts), 1);
    check({name, "_in"}, int'(sel_in), in);
    check({name, "_vc"}, int'(sel_vc), k);
  endtask

  initial begin
    rst = 1;
    clear_inputs();
    model_reset();
    do_reset();
    check("reset_cts", int'(cts), 0);
    check("reset_in", int'(sel_in), 0);
    check("reset_vc", int'(sel_vc), 0);
    check("reset_done", int'(pkt_done), 0);
    check("reset_abort", int'(abort), 0);

    // single request, three-beat packet
    req[2][4] = 1'b1;
    cycle(); lit_grant("t1_grant", 2, 4);
    valid = 1; cycle(); cycle();
    last = 1; req[2] = '0; cycle();
    check("t1_done", int'(pkt_done), 1);
    check("t1_cts_drop", int'(cts), 0);
    valid = 0; last = 0; cycle();
    check("t1_idle_cts", int'(cts), 0);

    // priority level 1 beats level 0, then bubble, then level 0
    req[0][1] = 1'b1; req[3][3] = 1'b1;
    cycle(); lit_grant("t2_high", 3, 3);
    req[3][3] = 1'b0; valid = 1; last = 1; cycle();
    check("t2_done", int'(pkt_done), 1);
    check("t2_bubble", int'(cts), 0);
    valid = 0; last = 0; cycle(); lit_grant("t2_low", 0, 1);
    req[0] = '0; valid = 1; last = 1; cycle();
    valid = 0; last = 0; cycle();

    // round-robin among four inputs on k=0, single-beat packets
    do_reset();
    for (int i = 0; i < 4; i++) req[i] = 6'b000001;
    valid = 1; last = 1;
    for (int g = 0; g < 5; g++) begin
      cycle(); lit_grant("t3_rr", g % 4, 0);
      cycle();
      check("t3_gap_cts", int'(cts), 0);
      check("t3_gap_done", int'(pkt_done), 1);
    end
    clear_inputs(); cycle();

    // credit masking
    do_reset();
    credit[5] = 1'b0; req[1][5] = 1'b1; req[2][2] = 1'b1;
    cycle(); lit_grant("t4_masked", 2, 2);
    credit[5] = 1'b1; req[2][2] = 1'b0; valid = 1; last = 1; cycle();
    valid = 0; last = 0; cycle(); lit_grant("t4_credit_back", 1, 5);
    req[1] = '0; valid = 1; last = 1; cycle();
    valid = 0; last = 0; cycle();

    // abort before first beat; no abort after first beat
    do_reset();
    req[1][2] = 1'b1;
    cycle(); lit_grant("t5_grant", 1, 2);
    req[1][2] = 1'b0; cycle();
    check("t5_abort", int'(abort), 1);
    check("t5_abort_cts", int'(cts), 0);
    req[1][2] = 1'b1; cycle(); cycle(); lit_grant("t5_regrant", 1, 2);
    valid = 1; req[1][2] = 1'b0; cycle();
    valid = 0; cycle(); cycle();
    check("t5_no_abort", int'(abort), 0);
    check("t5_hold_cts", int'(cts), 1);
    valid = 1; last = 1; cycle();
    check("t5_done", int'(pkt_done), 1);
    valid = 0; last = 0; cycle();

    // asynchronous reset in the middle of a grant
    do_reset();
    for (int i = 0; i < 4; i++) req[i] = 6'h3F;
    cycle(); lit_grant("t6_first", 0, 3);
    valid = 1; last = 1; cycle(); valid = 0; last = 0; cycle();
    lit_grant("t6_second", 0, 4);
    #2 rst = 1;
    #1 check("t6_async_cts", int'(cts), 0);
    check("t6_async_vc", int'(sel_vc), 0);
    model_reset();
    @(negedge clk);
    rst = 0;
    compare();
    cycle(); lit_grant("t6_after_reset", 0, 3);
    clear_inputs(); cycle(); cycle();

    // randomized traffic against the model
    do_reset();
    for (int c = 0; c < 3000; c++) begin
      for (int i = 0; i < 4; i++)
        if ($urandom_range(3) == 0) req[i] = 6'($urandom & $urandom);
      if ($urandom_range(7) == 0) credit = ~6'($urandom & $urandom & $urandom);
      valid = ($urandom_range(2) != 0);
      last  = ($urandom_range(3) == 0);
      cycle();
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
